// File: rtl/cross_bar_slave_port.sv
// Slave-side transaction port of the cross bar: locks the slave to the granted master,
// routes its request and returns ack/resp/rdata to the owner. Optional watchdog: CROSS_BAR_SLAVE_TIMEOUT_EN.

package cross_bar_pkg;
    localparam int MASTER_N = 4;
endpackage

module cross_bar_slave_port #(
    parameter int MASTER_N    = cross_bar_pkg::MASTER_N,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MASTER_N-1:0]          grant,
    input  logic [MASTER_N-1:0]          m_req,
    input  logic [MASTER_N*ADDR_W-1:0]   m_addr,
    input  logic [MASTER_N-1:0]          m_cmd,
    input  logic [MASTER_N*DATA_W-1:0]   m_wdata,
    output logic [MASTER_N-1:0]          m_ack,
    output logic [MASTER_N-1:0]          m_resp,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_cmd,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_ack,
    input  logic                         s_resp,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [$clog2(MASTER_N)-1:0]  owner,
    output logic                         busy,
    output logic                         err
);

    localparam int OWN_W = $clog2(MASTER_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [OWN_W-1:0]    owner_next;
    logic [MASTER_N-1:0] owner_oh;
    logic [MASTER_N-1:0] grant_oh_req;
    logic                grant_one;
    logic                grant_multi;
    logic [OWN_W-1:0]    grant_idx;
    logic                own_req;
    logic                own_grant;
    logic                own_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                timeout_hit;

    function automatic logic [OWN_W-1:0] onehot_idx(input logic [MASTER_N-1:0] v);
        logic [OWN_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            if (v[i]) begin
                idx = OWN_W'(i);
            end else begin
                idx = idx | {OWN_W{1'b0}};
            end
        end
        return idx;
    endfunction

    assign grant_one    = $onehot(grant);
    assign grant_multi  = (grant != {MASTER_N{1'b0}}) && !grant_one;
    assign grant_idx    = onehot_idx(grant);
    assign grant_oh_req = grant & m_req;

    // Owner-relative views so non-owners can never influence the transfer.
    assign owner_oh  = {{(MASTER_N-1){1'b0}}, 1'b1} << owner;
    assign own_req   = |(m_req & owner_oh);
    assign own_grant = |(grant & owner_oh);
    assign own_cmd   = |(m_cmd & owner_oh);

    // Owner field mux for the slave request channel
    always_comb begin
        sel_addr  = {ADDR_W{1'b0}};
        sel_wdata = {DATA_W{1'b0}};
        for (int i = 0; i < MASTER_N; i++) begin
            sel_addr  = sel_addr  | ({ADDR_W{owner_oh[i]}} & m_addr[i*ADDR_W +: ADDR_W]);
            sel_wdata = sel_wdata | ({DATA_W{owner_oh[i]}} & m_wdata[i*DATA_W +: DATA_W]);
        end
    end

`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] resp_cnt;

    // Response watchdog: zero outside RESP, counts cycles spent in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_cnt <= {CNT_W{1'b0}};
        end else if (state != RESP) begin
            resp_cnt <= {CNT_W{1'b0}};
        end else if (resp_cnt != CNT_W'(TIMEOUT_CYC)) begin
            resp_cnt <= resp_cnt + CNT_W'(1);
        end else begin
            resp_cnt <= resp_cnt;
        end
    end

    // A genuine response in the limit cycle still wins over the timeout.
    assign timeout_hit = (state == RESP) && (resp_cnt == CNT_W'(TIMEOUT_CYC)) && !s_resp;
`else
    assign timeout_hit = 1'b0;
`endif

    // State, owner and busy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= {OWN_W{1'b0}};
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Next-state and ownership decisions
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (grant_one && (grant_oh_req != {MASTER_N{1'b0}})) begin
                    state_next = ADDR;
                    owner_next = grant_idx;
                end else begin
                    state_next = IDLE;
                end
            end
            ADDR: begin
                if (s_ack) begin
                    state_next = own_cmd ? REL : RESP;
                end else begin
                    state_next = ADDR;
                end
            end
            RESP: begin
                if (s_resp || timeout_hit) begin
                    state_next = REL;
                end else begin
                    state_next = RESP;
                end
            end
            REL: begin
                if (!own_req) begin
                    state_next = IDLE;
                end else if (own_grant) begin
                    state_next = ADDR;
                end else begin
                    state_next = REL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slave channel and owner return path, all gated by state
    always_comb begin
        s_req   = 1'b0;
        s_addr  = {ADDR_W{1'b0}};
        s_cmd   = 1'b0;
        s_wdata = {DATA_W{1'b0}};
        m_ack   = {MASTER_N{1'b0}};
        m_resp  = {MASTER_N{1'b0}};
        m_rdata = {DATA_W{1'b0}};
        err     = 1'b0;
        case (state)
            IDLE: begin
                err = grant_multi;
            end
            ADDR: begin
                s_req   = 1'b1;
                s_addr  = sel_addr;
                s_cmd   = own_cmd;
                s_wdata = sel_wdata;
                m_ack   = s_ack ? owner_oh : {MASTER_N{1'b0}};
            end
            RESP: begin
                if (s_resp) begin
                    m_resp  = owner_oh;
                    m_rdata = s_rdata;
                end else if (timeout_hit) begin
                    m_resp  = owner_oh;
                    m_rdata = {DATA_W{1'b1}};
                    err     = 1'b1;
                end else begin
                    m_resp  = {MASTER_N{1'b0}};
                end
            end
            REL: begin
                s_req = 1'b0;
            end
            default: begin
                s_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cross_bar_slave_port.sv
// Self-checking bench for cross_bar_slave_port: directed test-plan steps plus randomized transfers,
// expectations derived from the transfer rules (grant -> ADDR -> ack -> [RESP] -> REL -> release).
module tb_cross_bar_slave_port;

    localparam int MN = cross_bar_pkg::MASTER_N;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = $clog2(MN);
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic              clk;
    logic              rst;
    logic [MN-1:0]     grant;
    logic [MN-1:0]     m_req;
    logic [MN*AW-1:0]  m_addr;
    logic [MN-1:0]     m_cmd;
    logic [MN*DW-1:0]  m_wdata;
    logic [MN-1:0]     m_ack;
    logic [MN-1:0]     m_resp;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic [AW-1:0]     s_addr;
    logic              s_cmd;
    logic [DW-1:0]     s_wdata;
    logic              s_ack;
    logic              s_resp;
    logic [DW-1:0]     s_rdata;
    logic [OW-1:0]     owner;
    logic              busy;
    logic              err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    cross_bar_slave_port #(
        .MASTER_N(MN), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .grant(grant), .m_req(m_req), .m_addr(m_addr),
        .m_cmd(m_cmd), .m_wdata(m_wdata), .m_ack(m_ack), .m_resp(m_resp),
        .m_rdata(m_rdata), .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd),
        .s_wdata(s_wdata), .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .owner(owner), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MN-1:0] oh(input int g);
        logic [MN-1:0] one;
        one = 1;
        return one << g;
    endfunction

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int g, input bit cmd, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        m_addr[g*AW +: AW]  = addr;
        m_wdata[g*DW +: DW] = wdata;
        m_cmd[g]            = cmd;
    endtask

    // One complete transfer by master g while the arbiter's grant wanders elsewhere mid-transfer.
    task automatic xfer(input int g, input bit cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int ack_dly, input int resp_dly);
        logic [MN-1:0] g_oh;
        logic [MN-1:0] noise;
        g_oh  = oh(g);
        noise = MN'($urandom);
        m_cmd = MN'($urandom);
        set_master(g, cmd, addr, wdata);
        m_req = noise | g_oh;
        grant = g_oh;
        sample();
        check("idle_sreq", s_req, 0);
        check("idle_err", err, 0);
        drive_edge();
        grant = oh((g + 1) % MN);
        for (int i = 0; i < ack_dly; i++) begin
            s_resp  = 1'($urandom);
            s_rdata = $urandom;
            sample();
            check("addr_sreq", s_req, 1);
            check("addr_saddr", s_addr, addr);
            check("addr_scmd", s_cmd, cmd);
            check("addr_swdata", s_wdata, wdata);
            check("addr_owner", owner, g);
            check("addr_mack", m_ack, 0);
            check("addr_mresp", m_resp, 0);
            check("addr_mrdata", m_rdata, 0);
            check("addr_busy", busy, 1);
            drive_edge();
        end
        s_resp = 1'b0;
        s_ack  = 1'b1;
        sample();
        check("ack_sreq", s_req, 1);
        check("ack_saddr", s_addr, addr);
        check("ack_mack", m_ack, g_oh);
        check("ack_owner", owner, g);
        drive_edge();
        s_ack = 1'b0;
        if (!cmd) begin
            for (int i = 0; i < resp_dly; i++) begin
                s_ack   = 1'($urandom);
                s_rdata = $urandom;
                sample();
                check("resp_sreq", s_req, 0);
                check("resp_mack", m_ack, 0);
                check("resp_mresp", m_resp, 0);
                check("resp_mrdata", m_rdata, 0);
                check("resp_busy", busy, 1);
                drive_edge();
            end
            s_ack   = 1'b0;
            s_resp  = 1'b1;
            s_rdata = rdata;
            sample();
            check("rd_mresp", m_resp, g_oh);
            check("rd_mrdata", m_rdata, rdata);
            check("rd_err", err, 0);
            drive_edge();
            s_resp  = 1'b0;
            s_rdata = $urandom;
        end
        sample();
        check("rel_sreq", s_req, 0);
        check("rel_busy", busy, 1);
        check("rel_owner", owner, g);
        check("rel_mrdata", m_rdata, 0);
        drive_edge();
        m_req = noise & ~g_oh;
        grant = '0;
        sample();
        check("rel_drop_busy", busy, 1);
        drive_edge();
        m_req = '0;
        sample();
        check("released_busy", busy, 0);
        check("released_sreq", s_req, 0);
        drive_edge();
    endtask

    initial begin
        int g;
        rst = 1'b1; grant = '0; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        sample();
        check("rst_sreq", s_req, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_owner", owner, 0);
        check("rst_mack", m_ack, 0);
        check("rst_mresp", m_resp, 0);
        check("rst_mrdata", m_rdata, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_swdata", s_wdata, 0);
        check("rst_scmd", s_cmd, 0);
        drive_edge();

        // Write and read from the test plan
        xfer(0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 32'h0, 2, 0);
        xfer(1, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 2);

        // Back-to-back writes by master 0 with grant held
        m_cmd = '0;
        set_master(0, 1'b1, 32'h0000_0300, 32'h0B2B_0001);
        m_req = oh(0);
        grant = oh(0);
        drive_edge();
        s_ack = 1'b1;
        sample();
        check("b2b_ack1", m_ack, oh(0));
        check("b2b_addr1", s_addr, 32'h0000_0300);
        drive_edge();
        s_ack = 1'b0;
        set_master(0, 1'b1, 32'h0000_0304, 32'h0B2B_0002);
        sample();
        check("b2b_rel_sreq", s_req, 0);
        check("b2b_rel_busy", busy, 1);
        check("b2b_rel_owner", owner, 0);
        drive_edge();
        s_ack = 1'b1;
        sample();
        check("b2b_sreq2", s_req, 1);
        check("b2b_busy2", busy, 1);
        check("b2b_addr2", s_addr, 32'h0000_0304);
        check("b2b_wdata2", s_wdata, 32'h0B2B_0002);
        check("b2b_ack2", m_ack, oh(0));
        check("b2b_owner2", owner, 0);
        drive_edge();
        s_ack = 1'b0;
        m_req = '0;
        grant = '0;
        sample();
        check("b2b_rel2_busy", busy, 1);
        drive_edge();
        sample();
        check("b2b_idle_busy", busy, 0);
        drive_edge();

        // Multi-hot grant in IDLE
        m_req = oh(0) | oh(1);
        grant = oh(0) | oh(1);
        sample();
        check("multi_err", err, 1);
        check("multi_sreq", s_req, 0);
        drive_edge();
        grant = '0;
        sample();
        check("multi_after_sreq", s_req, 0);
        check("multi_after_busy", busy, 0);
        check("multi_after_err", err, 0);
        drive_edge();
        m_req = '0;

        // Read with no slave response
        g = MN - 1;
        set_master(g, 1'b0, 32'h0000_0400, 32'h0);
        m_req = oh(g);
        grant = oh(g);
        drive_edge();
        grant = '0;
        s_ack = 1'b1;
        sample();
        check("to_ack", m_ack, oh(g));
        drive_edge();
        s_ack = 1'b0;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            sample();
            check("to_wait_mresp", m_resp, 0);
            check("to_wait_err", err, 0);
            drive_edge();
        end
        sample();
        check("to_mresp", m_resp, oh(g));
        check("to_mrdata", m_rdata, 32'hFFFF_FFFF);
        check("to_err", err, 1);
        drive_edge();
        s_resp  = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        sample();
        check("to_late_mresp", m_resp, 0);
        check("to_late_mrdata", m_rdata, 0);
        check("to_late_err", err, 0);
        check("to_late_busy", busy, 1);
        drive_edge();
        s_resp = 1'b0;
`else
        repeat (1000) drive_edge();
        sample();
        check("noto_busy", busy, 1);
        check("noto_mresp", m_resp, 0);
        check("noto_err", err, 0);
        check("noto_sreq", s_req, 0);
        drive_edge();
        s_resp  = 1'b1;
        s_rdata = 32'hCAFE_0001;
        sample();
        check("noto_mresp_late", m_resp, oh(g));
        check("noto_mrdata_late", m_rdata, 32'hCAFE_0001);
        drive_edge();
        s_resp = 1'b0;
`endif
        m_req = '0;
        sample();
        check("to_rel_busy", busy, 1);
        drive_edge();
        sample();
        check("to_idle_busy", busy, 0);
        drive_edge();

        // Reset in the middle of a read
        set_master(1, 1'b0, 32'h0000_0500, 32'h0);
        m_req = oh(1);
        grant = oh(1);
        drive_edge();
        grant = '0;
        s_ack = 1'b1;
        drive_edge();
        s_ack = 1'b0;
        sample();
        check("mid_busy", busy, 1);
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst     = 1'b0;
        m_req   = '0;
        s_resp  = 1'b1;
        s_rdata = 32'h5555_AAAA;
        sample();
        check("mrst_busy", busy, 0);
        check("mrst_sreq", s_req, 0);
        check("mrst_owner", owner, 0);
        check("mrst_mresp", m_resp, 0);
        check("mrst_mrdata", m_rdata, 0);
        check("mrst_mack", m_ack, 0);
        check("mrst_err", err, 0);
        check("mrst_saddr", s_addr, 0);
        drive_edge();
        s_resp = 1'b0;

        // Randomized transfers
        for (int n = 0; n < 30; n++) begin
            xfer($urandom_range(MN - 1, 0), 1'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(3, 0), $urandom_range(5, 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
